// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: instruction-fetch responder with programmable latency, stall, and preload port
module inst_fetch_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  output logic        stall
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);
  localparam logic [3:0]  CNT0 = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, inst_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];
  logic        accept, go_resp, rd_ok, ld_ok;
  logic [31:0] rd_addr;
  logic [32:0] rd_diff, ld_diff;
  // 33-bit offsets: an address below BASE_ADDR borrows into bit 32 and fails the span compare
  always_comb begin
    accept  = req_valid && (state_q != WAIT || flush);
    go_resp = (accept && LATENCY == 1) || (!flush && state_q == WAIT && cnt_q == 4'd0);
    rd_addr = LATENCY == 1 ? req_addr : addr_q;
    rd_diff = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    ld_diff = {1'b0, load_addr} - {1'b0, BASE_ADDR};
    rd_ok   = rd_addr[1:0] == 2'b00 && rd_diff < SPAN;
    ld_ok   = load_addr[1:0] == 2'b00 && ld_diff < SPAN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        state_q <= LATENCY == 1 ? RESP : WAIT;
        cnt_q   <= CNT0;
      end else if (flush || state_q == RESP) begin
        state_q <= IDLE;
      end else if (state_q == WAIT) begin
        state_q <= cnt_q == 4'd0 ? RESP : WAIT;
        cnt_q   <= cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      if (go_resp) begin
        inst_q <= rd_ok ? mem_q[rd_diff[AW+1:2]] : 32'd0;
        err_q  <= !rd_ok;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (load_en && ld_ok) mem_q[ld_diff[AW+1:2]] <= load_data;
  end
  assign resp_valid = state_q == RESP;
  assign stall      = state_q == WAIT;
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;
endmodule
